// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one Wishbone-style memory bus between the instruction-fetch master
// (IF stage) and the data master (MEM stage). Data has fixed priority over
// fetch. A fetch that is cancelled by a pipeline flush is still completed on
// the bus (a slave cycle is never aborted), but its data is discarded and no
// fetch acknowledge is given.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_req_i          fetch request (level, held until if_ack_o)
//   if_addr_i         fetch address
//   if_rdata_o        fetch read data (zero unless if_ack_o)
//   if_ack_o          fetch complete, one-cycle pulse
//   d_req_i           data request (level, held until d_ack_o)
//   d_we_i            data write enable
//   d_sel_i           data byte enables
//   d_addr_i          data address
//   d_wdata_i         data write data
//   d_rdata_o         data read data (zero unless d_ack_o)
//   d_ack_o           data complete, one-cycle pulse
//   flush_i           pipeline flush, cancels current or pending fetch
//   bus_cyc_o         bus cycle active
//   bus_we_o          bus write enable
//   bus_sel_o         bus byte enables
//   bus_addr_o        bus address
//   bus_wdata_o       bus write data
//   bus_rdata_i       bus read data
//   bus_ack_i         bus acknowledge
//   stallreq_o        stall request while any master is waiting
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_ack_o,

    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_W/8-1:0]   d_sel_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  d_ack_o,

    input  logic                  flush_i,

    output logic                  bus_cyc_o,
    output logic                  bus_we_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i,

    output logic                  stallreq_o
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2,
        ST_IF_DROP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                cyc_q,   cyc_d;
    logic                we_q,    we_d;
    logic [SEL_W-1:0]    sel_q,   sel_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                if_ack_s;
    logic                d_ack_s;

    // Next-state, bus register next values and master acknowledges
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if_ack_s = 1'b0;
        d_ack_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_req_i) begin
                    // Data wins over fetch; flush has no say here.
                    state_d = ST_D_BUSY;
                    cyc_d   = 1'b1;
                    we_d    = d_we_i;
                    sel_d   = d_sel_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                end else if (if_req_i && !flush_i) begin
                    state_d = ST_IF_BUSY;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = {SEL_W{1'b1}};
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                end
            end

            ST_D_BUSY: begin
                if (bus_ack_i) begin
                    d_ack_s = 1'b1;
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                end else begin
                    state_d = ST_D_BUSY;
                end
            end

            ST_IF_BUSY: begin
                if (bus_ack_i) begin
                    // A flush in the completing cycle swallows the data.
                    if_ack_s = !flush_i;
                    state_d  = ST_IDLE;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    sel_d    = '0;
                    addr_d   = '0;
                    wdata_d  = '0;
                end else if (flush_i) begin
                    // Bus cycle keeps running; only the result is dropped.
                    state_d = ST_IF_DROP;
                end else begin
                    state_d = ST_IF_BUSY;
                end
            end

            ST_IF_DROP: begin
                if (bus_ack_i) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                end else begin
                    state_d = ST_IF_DROP;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                sel_d   = '0;
                addr_d  = '0;
                wdata_d = '0;
            end
        endcase
    end

    // State and bus output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus_cyc_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

    // Acks are combinational so a zero-wait slave completes in two cycles.
    assign if_ack_o   = if_ack_s;
    assign d_ack_o    = d_ack_s;
    assign if_rdata_o = if_ack_s ? bus_rdata_i : '0;
    assign d_rdata_o  = d_ack_s  ? bus_rdata_i : '0;

    assign stallreq_o = (if_req_i & ~if_ack_s) | (d_req_i & ~d_ack_s);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave bus arbiter that shares the single external memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the pipeline. Each master uses a level request and a one-cycle acknowledge. The slave side is a Wishbone-style cyc/ack bus. The block raises a stall request to `ctrl` while any master is waiting, and it discards fetch data when `flush_i` cancels an in-flight fetch.

## Interface
- `ADDR_W`, default 32: address width for all ports.
- `DATA_W`, default 32: data width for all ports; `DATA_W/8` byte lanes.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req_i`  in  1  fetch request; held high until `if_ack_o`.
- `if_addr_i`  in  ADDR_W  fetch address; stable while `if_req_i` is high.
- `if_rdata_o`  out  DATA_W  fetch read data; valid only with `if_ack_o`.
- `if_ack_o`  out  1  fetch complete (one-cycle pulse).
- `d_req_i`  in  1  data request; held high until `d_ack_o`.
- `d_we_i`  in  1  data write enable (1 = write).
- `d_sel_i`  in  DATA_W/8  data byte enables.
- `d_addr_i`  in  ADDR_W  data address.
- `d_wdata_i`  in  DATA_W  data write data.
- `d_rdata_o`  out  DATA_W  data read data; valid only with `d_ack_o`.
- `d_ack_o`  out  1  data access complete (one-cycle pulse).
- `flush_i`  in  1  pipeline flush; cancels the current or pending fetch.
- `bus_cyc_o`  out  1  bus cycle active.
- `bus_we_o`  out  1  bus write enable.
- `bus_sel_o`  out  DATA_W/8  bus byte enables.
- `bus_addr_o`  out  ADDR_W  bus address.
- `bus_wdata_o`  out  DATA_W  bus write data.
- `bus_rdata_i`  in  DATA_W  bus read data.
- `bus_ack_i`  in  1  bus acknowledge; may arrive in the same cycle as `bus_cyc_o` rises.
- `stallreq_o`  out  1  stall request to `ctrl`.

## Operation
- States: IDLE, IF_BUSY, D_BUSY, IF_DROP.
- **IDLE**
  - If `d_req_i`: go to D_BUSY. Latch `d_we_i`, `d_sel_i`, `d_addr_i`, `d_wdata_i` into the bus registers and set `bus_cyc_o`. Data has fixed priority over fetch.
  - Else if `if_req_i` and not `flush_i`: go to IF_BUSY. Set `bus_we_o`=0 and `bus_sel_o`=all ones, latch `if_addr_i`, set `bus_cyc_o`.
  - Else stay in IDLE with `bus_cyc_o`=0.
- **D_BUSY**
  - Hold all bus outputs.
  - On `bus_ack_i`: `d_ack_o`=1 combinationally, `d_rdata_o`=`bus_rdata_i`. Next state is IDLE and `bus_cyc_o` clears.
- **IF_BUSY**
  - On `bus_ack_i` with no `flush_i`: `if_ack_o`=1, `if_rdata_o`=`bus_rdata_i`. Next state is IDLE.
  - On `flush_i` without `bus_ack_i`: go to IF_DROP.
  - On `flush_i` together with `bus_ack_i`: suppress `if_ack_o` and go to IDLE.
- **IF_DROP**
  - The bus transaction is never aborted. Hold bus outputs until `bus_ack_i`, suppress `if_ack_o`, then go to IDLE.
- Read data outputs are 0 whenever their ack is 0.
- `bus_we_o`, `bus_sel_o`, `bus_addr_o`, `bus_wdata_o` return to 0 when the bus cycle ends.
- `stallreq_o` = (`if_req_i` & ~`if_ack_o`) | (`d_req_i` & ~`d_ack_o`), combinational. It also covers any request parked in IDLE.
- `flush_i` never affects a data transaction.

## Timing
- Reset: state = IDLE. `bus_cyc_o`, `bus_we_o`, `bus_sel_o`, `bus_addr_o`, `bus_wdata_o` = 0. `if_ack_o`, `d_ack_o`, `if_rdata_o`, `d_rdata_o` = 0.
- Reset asserted mid-transaction forces IDLE on the next edge and drops `bus_cyc_o`. Any late `bus_ack_i` is ignored.
- Latency with a zero-wait slave:
  - Cycle 0: request sampled in IDLE.
  - Cycle 1: `bus_cyc_o`=1, `bus_ack_i` arrives, master ack pulses.
  - Cycle 2: back in IDLE.
  - The minimum is 2 cycles per access. Each slave wait state adds 1 cycle.
- Back-to-back requests: after an ack, the master deasserts or renews its request on the next edge. The arbiter samples it in IDLE one cycle later, so there is always one bus-idle cycle between transactions.
- Simultaneous `if_req_i` and `d_req_i` in IDLE: data is granted first. The fetch is granted in the next IDLE cycle if `d_req_i` is then low.
- Ack outputs never assert outside BUSY states. At most one ack is high per cycle.

## Test plan
- **Zero-wait fetch.** `if_req_i`=1, `if_addr_i`=0x0000_0010, slave returns `bus_ack_i` the same cycle with 0x3401_1100 → `bus_cyc_o` high in cycle 1 with `bus_sel_o`=4'hF and `bus_we_o`=0; `if_ack_o`=1 with `if_rdata_o`=0x3401_1100 in cycle 1; `stallreq_o` high in cycle 0 only.
- **Simultaneous requests.** `d_req_i` (write, 0x100, data 0xDEAD_BEEF, sel 4'b0011) and `if_req_i` in the same cycle → data bus cycle first with `bus_wdata_o`=0xDEAD_BEEF and `bus_sel_o`=4'b0011; `d_ack_o` on `bus_ack_i`; fetch bus cycle starts 2 cycles after `d_ack_o`; `stallreq_o` stays high throughout.
- **Wait states.** Data read at 0x200, slave adds 3 wait cycles → bus outputs stable for 4 cycles; `d_ack_o` is exactly one cycle with `d_rdata_o`=`bus_rdata_i`; `d_rdata_o`=0 on all other cycles.
- **Flush during fetch.** Fetch at 0x40, slave waits 2 cycles, `flush_i` pulsed in the first busy cycle → state IF_DROP; `bus_cyc_o` held until `bus_ack_i`; `if_ack_o` never asserts; IDLE afterwards.
- **Reset mid-transaction.** `rst` asserted during D_BUSY → next edge: all outputs 0; a `bus_ack_i` one cycle later produces no `d_ack_o`.
- **Flush ignored for data.** `flush_i`=1 during D_BUSY → `d_ack_o` still issued normally.
